div_ctrl: RTL
=============

// Module: div_ctrl
// PURPOSE
//   Sequences the shared 32-bit multi-cycle unsigned divider for RV32M DIV/DIVU/REM/REMU.
//   Accepts one request at a time from the EX stage over a valid/ready handshake.
//   Applies sign conversion around the divider and resolves RISC-V special cases without starting it.
//   Supports a pipeline flush that discards an in-flight operation.
// PARAMETERS
//   XLEN   32  operand/result width; must match the divider width
//   TAG_W  5   width of the opaque tag (rd index) carried from request to response
// PORTS
//   clk              in   1      clock
//   rst              in   1      asynchronous, active-high reset
//   req_valid        in   1      request present
//   req_ready        out  1      controller can accept; high only in IDLE
//   req_op           in   2      00 DIV, 01 DIVU, 10 REM, 11 REMU (funct3[1:0])
//   req_a / req_b    in   XLEN   dividend / divisor (rs1 / rs2)
//   req_tag          in   TAG_W  returned unchanged on resp_tag
//   flush            in   1      kill the accepted or in-flight request
//   resp_valid       out  1      result available
//   resp_ready       in   1      consumer takes result
//   resp_data        out  XLEN   quotient (DIV/DIVU) or remainder (REM/REMU)
//   resp_tag         out  TAG_W  tag of the completed request
//   div_start        out  1      one-cycle start pulse to the divider
//   div_dividend     out  XLEN   divider operand; held stable from start through finish
//   div_divisor      out  XLEN   divider operand; held stable from start through finish
//   div_finish       in   1      divider done pulse
//   div_res/div_rem  in   XLEN   divider quotient / remainder, valid while div_finish is high
// BEHAVIOUR
//   Reset: state IDLE; req_ready=1; resp_valid=0; div_start=0; resp_data, resp_tag, div_* operands=0; cache invalid.
//   FSM: IDLE -> START -> WAIT -> DONE -> IDLE; plus DRAIN.
//   IDLE: accept on req_valid&&req_ready (cycle T); latch op, tag, a, b.
//     Signed op: take |a| and |b|; record neg_q = a[31]^b[31] and neg_r = a[31].
//     b==0: bypass to DONE; quotient=all-ones, remainder=a.
//     Signed a==0x80000000 with b==all-ones: bypass to DONE; quotient=0x80000000, remainder=0.
//     Bypassed requests never assert div_start; resp_valid at T+1.
//   START: div_start=1 for exactly one cycle (T+1); go to WAIT.
//   WAIT: on div_finish, capture div_res/div_rem and go to DONE.
//     The divider's divide_zero output is ignored (zero divisor is never issued).
//   DONE: resp_valid=1.
//     resp_data = negate-if-neg_q(quotient) for DIV, negate-if-neg_r(remainder) for REM; unsigned ops unmodified.
//     resp_data and resp_tag are stable while resp_valid && !resp_ready.
//     resp_valid&&resp_ready -> IDLE; the next request is accepted no earlier than the following cycle.
//   Latency, normal path: resp_valid exactly 1 cycle after the div_finish cycle.
//   Negation is two's complement modulo 2^XLEN.
//   flush has priority over everything except reset:
//     IDLE with a same-cycle request: the request is not accepted.
//     START or WAIT: go to DRAIN, because the divider cannot abort.
//       DRAIN holds req_ready=0 until div_finish, then returns to IDLE; the result is discarded.
//       If div_finish and flush arrive in the same WAIT cycle, go to IDLE directly.
//     DONE: drop resp_valid next cycle and return to IDLE.
//   Async rst at any point, including WAIT: immediate return to reset values.
//     The divider shares rst, so no drain is needed.
// CONFIGURATION
//   DIV_RESULT_CACHE_EN defined:
//     Keep the key {signedness, a, b} of the last completed non-flushed divide, with its final signed quotient and remainder.
//     A matching request in IDLE goes to DONE with resp_valid at T+1 and no div_start.
//     A REM following a DIV on the same operands hits, and vice versa.
//     The cache is invalidated on rst only; bypass results are not cached.
//   Not defined: no cache storage; every non-special request uses the divider.
// STRUCTURE
//   div_pkg: op encodings (OP_DIV, OP_DIVU, OP_REM, OP_REMU), FSM state enum
//     (S_IDLE, S_START, S_WAIT, S_DONE, S_DRAIN), DIV_ZERO_Q all-ones, INT_MIN constant.
//   One sub-module, div_sign_fix: combinational abs/negate and special-case detection,
//     shared by the pre-divide and post-divide paths.
//   The divider itself is instantiated by the parent, not inside div_ctrl.
// TESTING
//   1. DIV -7 / 2 -> div_start once; resp_data 0xFFFFFFFD.
//      REM -7 / 2 -> 0xFFFFFFFF.
//      Both: resp_valid exactly 1 cycle after div_finish.
//   2. DIVU 100 / 7 -> 14; REMU 100 / 7 -> 2.
//      DIVU 0xFFFFFFFF / 1 -> 0xFFFFFFFF.
//   3. DIV 5 / 0 -> 0xFFFFFFFF; REM 5 / 0 -> 5.
//      DIV 0x80000000 / 0xFFFFFFFF -> 0x80000000; REM of the same -> 0.
//      All four: resp_valid at T+1, div_start never asserted.
//   4. Flush 2 cycles after div_start:
//      -> no resp_valid; req_ready=0 until div_finish, then 1.
//      -> next request completes correctly.
//   5. Hold resp_ready=0 for 3 cycles in DONE -> resp_data/resp_tag unchanged; single handoff on release.
//      Assert rst mid-WAIT -> all outputs at reset values in the same cycle.
//   6. With DIV_RESULT_CACHE_EN: DIV 1000 / 7, then REM 1000 / 7.
//      -> second returns 6 at T+1 with no div_start.
//      -> the same sequence without the macro issues two starts.

Source files
------------

// File: rtl/div_pkg.sv
`default_nettype none
// ============================================================================
// Module   : div_pkg
// Purpose  : Shared definitions for the RV32M divide controller: operation
//            encodings (funct3[1:0]), FSM state encoding, RISC-V special-case
//            result constants and small operation-decode helpers.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package div_pkg;

  localparam int XLEN_DEF = 32;

  // funct3[1:0] of the M-extension divide group
  localparam logic [1:0] OP_DIV  = 2'b00;
  localparam logic [1:0] OP_DIVU = 2'b01;
  localparam logic [1:0] OP_REM  = 2'b10;
  localparam logic [1:0] OP_REMU = 2'b11;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_START = 3'd1,
    S_WAIT  = 3'd2,
    S_DONE  = 3'd3,
    S_DRAIN = 3'd4
  } state_e;

  // Quotient returned for a zero divisor
  localparam logic [XLEN_DEF-1:0] DIV_ZERO_Q = {XLEN_DEF{1'b1}};
  // Most negative signed value; INT_MIN / -1 overflows back to itself
  localparam logic [XLEN_DEF-1:0] INT_MIN    = {1'b1, {(XLEN_DEF-1){1'b0}}};

  function automatic logic op_is_signed(input logic [1:0] op);
    return (op != OP_DIVU) && (op != OP_REMU);
  endfunction

  function automatic logic op_is_rem(input logic [1:0] op);
    return (op == OP_REM) || (op == OP_REMU);
  endfunction

endpackage
`default_nettype wire

// File: rtl/div_sign_fix.sv
`default_nettype none
// ============================================================================
// Module   : div_sign_fix
// Purpose  : Combinational sign handling around the unsigned divider.
//            Pre-divide : absolute values of the operands, result sign flags,
//                         zero-divisor and signed-overflow detection.
//            Post-divide: conditional two's-complement negation of the raw
//                         quotient and remainder.
// Ports    : signed_i        operation is signed (DIV/REM)
//            a_i / b_i       original dividend / divisor
//            abs_a_o/abs_b_o operands to present to the unsigned divider
//            neg_q_o/neg_r_o quotient / remainder must be negated afterwards
//            div0_o          divisor is zero
//            ovf_o           signed INT_MIN / -1
//            quot_i/rem_i    raw unsigned divider results
//            neg_q_i/neg_r_i negate flags recorded at accept time
//            quot_o/rem_o    final quotient / remainder
// Revision : 1.0 - initial release
// ============================================================================
module div_sign_fix import div_pkg::*; #(
  parameter int XLEN = 32
) (
  input  logic            signed_i,
  input  logic [XLEN-1:0] a_i,
  input  logic [XLEN-1:0] b_i,
  output logic [XLEN-1:0] abs_a_o,
  output logic [XLEN-1:0] abs_b_o,
  output logic            neg_q_o,
  output logic            neg_r_o,
  output logic            div0_o,
  output logic            ovf_o,
  input  logic [XLEN-1:0] quot_i,
  input  logic [XLEN-1:0] rem_i,
  input  logic            neg_q_i,
  input  logic            neg_r_i,
  output logic [XLEN-1:0] quot_o,
  output logic [XLEN-1:0] rem_o
);

  logic w_a_neg;
  logic w_b_neg;

  assign w_a_neg = signed_i & a_i[XLEN-1];
  assign w_b_neg = signed_i & b_i[XLEN-1];

  // |INT_MIN| wraps to INT_MIN, which is the correct unsigned magnitude
  assign abs_a_o = w_a_neg ? (~a_i + 1'b1) : a_i;
  assign abs_b_o = w_b_neg ? (~b_i + 1'b1) : b_i;

  // The remainder takes the sign of the dividend
  assign neg_q_o = w_a_neg ^ w_b_neg;
  assign neg_r_o = w_a_neg;

  assign div0_o  = (b_i == '0);
  assign ovf_o   = signed_i && (a_i == INT_MIN) && (b_i == DIV_ZERO_Q);

  assign quot_o  = neg_q_i ? (~quot_i + 1'b1) : quot_i;
  assign rem_o   = neg_r_i ? (~rem_i  + 1'b1) : rem_i;

endmodule
`default_nettype wire

// File: rtl/div_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : div_ctrl
// Purpose  : Sequences the shared multi-cycle unsigned divider for RV32M
//            DIV/DIVU/REM/REMU. One request at a time over valid/ready; sign
//            conversion around the divider; zero-divisor and INT_MIN/-1 are
//            answered without starting the divider; flush discards the
//            in-flight operation (draining the divider when it is busy).
//            Optional build macro DIV_RESULT_CACHE_EN keeps the last divider
//            result so a DIV/REM pair on the same operands divides once.
// Ports    : clk, rst                 clock, async active-high reset
//            req_valid/req_ready      request handshake (ready only in IDLE)
//            req_op, req_a, req_b     funct3[1:0], dividend, divisor
//            req_tag                  opaque tag returned on resp_tag
//            flush                    kill the accepted / in-flight request
//            resp_valid/resp_ready    response handshake
//            resp_data, resp_tag      result and its tag
//            div_start                one-cycle divider start pulse
//            div_dividend/div_divisor divider operands (stable while busy)
//            div_finish               divider done pulse
//            div_res/div_rem          divider quotient / remainder
// Revision : 1.0 - initial release
// ============================================================================
module div_ctrl import div_pkg::*; #(
  parameter int XLEN  = 32,
  parameter int TAG_W = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [1:0]       req_op,
  input  logic [XLEN-1:0]  req_a,
  input  logic [XLEN-1:0]  req_b,
  input  logic [TAG_W-1:0] req_tag,
  input  logic             flush,
  output logic             resp_valid,
  input  logic             resp_ready,
  output logic [XLEN-1:0]  resp_data,
  output logic [TAG_W-1:0] resp_tag,
  output logic             div_start,
  output logic [XLEN-1:0]  div_dividend,
  output logic [XLEN-1:0]  div_divisor,
  input  logic             div_finish,
  input  logic [XLEN-1:0]  div_res,
  input  logic [XLEN-1:0]  div_rem
);

  state_e           state_q, state_d;
  logic [1:0]       op_q;
  logic [XLEN-1:0]  dividend_q, divisor_q;
  logic [XLEN-1:0]  resp_data_q;
  logic [TAG_W-1:0] resp_tag_q;
  logic             neg_q_q, neg_r_q;

  logic             w_signed;
  logic [XLEN-1:0]  w_abs_a, w_abs_b;
  logic             w_neg_q, w_neg_r;
  logic             w_div0, w_ovf;
  logic [XLEN-1:0]  w_fix_q, w_fix_r;
  logic [XLEN-1:0]  w_byp_q, w_byp_r;
  logic             w_accept, w_bypass, w_capture;
  logic             w_cache_hit;
  logic [XLEN-1:0]  w_cache_q, w_cache_r;

  function automatic logic [XLEN-1:0] pick(input logic [1:0]      op,
                                           input logic [XLEN-1:0] q,
                                           input logic [XLEN-1:0] r);
    case (op)
      OP_DIV, OP_DIVU: pick = q;
      default:         pick = r;
    endcase
  endfunction

  assign w_signed = op_is_signed(req_op);

  div_sign_fix #(.XLEN(XLEN)) u_sign_fix (
    .signed_i (w_signed),
    .a_i      (req_a),
    .b_i      (req_b),
    .abs_a_o  (w_abs_a),
    .abs_b_o  (w_abs_b),
    .neg_q_o  (w_neg_q),
    .neg_r_o  (w_neg_r),
    .div0_o   (w_div0),
    .ovf_o    (w_ovf),
    .quot_i   (div_res),
    .rem_i    (div_rem),
    .neg_q_i  (neg_q_q),
    .neg_r_i  (neg_r_q),
    .quot_o   (w_fix_q),
    .rem_o    (w_fix_r)
  );

  // Special-case results: x/0 -> {all-ones, x}; INT_MIN/-1 -> {INT_MIN, 0}
  assign w_byp_q   = w_div0 ? DIV_ZERO_Q : INT_MIN;
  assign w_byp_r   = w_div0 ? req_a : '0;

  // flush outranks a same-cycle request
  assign w_accept  = (state_q == S_IDLE) && req_valid && !flush;
  assign w_bypass  = w_div0 || w_ovf;
  // A finish coinciding with flush is discarded
  assign w_capture = (state_q == S_WAIT) && div_finish && !flush;

`ifdef DIV_RESULT_CACHE_EN
  logic            cache_vld_q;
  logic            cache_sgn_q, key_sgn_q;
  logic [XLEN-1:0] cache_a_q, cache_b_q, key_a_q, key_b_q;
  logic [XLEN-1:0] cache_quo_q, cache_rem_q;

  // Key of the in-flight divide is held until its result is captured so a
  // flushed or reset operation never populates the cache.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cache_vld_q <= 1'b0;
      cache_sgn_q <= 1'b0;
      cache_a_q   <= '0;
      cache_b_q   <= '0;
      cache_quo_q <= '0;
      cache_rem_q <= '0;
      key_sgn_q   <= 1'b0;
      key_a_q     <= '0;
      key_b_q     <= '0;
    end else begin
      if (w_accept && !w_bypass && !w_cache_hit) begin
        key_sgn_q <= w_signed;
        key_a_q   <= req_a;
        key_b_q   <= req_b;
      end
      if (w_capture) begin
        cache_vld_q <= 1'b1;
        cache_sgn_q <= key_sgn_q;
        cache_a_q   <= key_a_q;
        cache_b_q   <= key_b_q;
        cache_quo_q <= w_fix_q;
        cache_rem_q <= w_fix_r;
      end
    end
  end

  assign w_cache_hit = cache_vld_q && (cache_sgn_q == w_signed) &&
                       (cache_a_q == req_a) && (cache_b_q == req_b);
  assign w_cache_q   = cache_quo_q;
  assign w_cache_r   = cache_rem_q;
`else
  assign w_cache_hit = 1'b0;
  assign w_cache_q   = '0;
  assign w_cache_r   = '0;
`endif

  // FSM state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // FSM next-state
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (w_accept) state_d = (w_bypass || w_cache_hit) ? S_DONE : S_START;
      end
      // The start pulse has already gone out, so a flush here must drain
      S_START: state_d = flush ? S_DRAIN : S_WAIT;
      S_WAIT: begin
        if (flush)           state_d = div_finish ? S_IDLE : S_DRAIN;
        else if (div_finish) state_d = S_DONE;
      end
      S_DONE: begin
        if (flush || resp_ready) state_d = S_IDLE;
      end
      S_DRAIN: begin
        if (div_finish) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // FSM outputs
  always_comb begin
    req_ready  = (state_q == S_IDLE);
    resp_valid = (state_q == S_DONE);
    div_start  = (state_q == S_START);
  end

  // Datapath registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      op_q        <= OP_DIV;
      dividend_q  <= '0;
      divisor_q   <= '0;
      neg_q_q     <= 1'b0;
      neg_r_q     <= 1'b0;
      resp_data_q <= '0;
      resp_tag_q  <= '0;
    end else begin
      if (w_accept) begin
        op_q       <= req_op;
        resp_tag_q <= req_tag;
        if (w_bypass) begin
          resp_data_q <= pick(req_op, w_byp_q, w_byp_r);
        end else if (w_cache_hit) begin
          resp_data_q <= pick(req_op, w_cache_q, w_cache_r);
        end else begin
          // Operands only change on a divider-bound accept, keeping them
          // stable from start through finish
          dividend_q <= w_abs_a;
          divisor_q  <= w_abs_b;
          neg_q_q    <= w_neg_q;
          neg_r_q    <= w_neg_r;
        end
      end
      if (w_capture) resp_data_q <= pick(op_q, w_fix_q, w_fix_r);
    end
  end

  assign resp_data    = resp_data_q;
  assign resp_tag     = resp_tag_q;
  assign div_dividend = dividend_q;
  assign div_divisor  = divisor_q;

endmodule
`default_nettype wire
